// File: rtl/hes_msg_framer_if.sv
// Source-side byte stream into the HES message framer.
//   s_valid / s_ready : ready/valid handshake (byte moves when both high at clk)
//   s_data            : plaintext byte
//   s_first / s_last  : message framing marks (may both be set for a 1-byte message)
// master = byte source, slave = framer.
interface hes_msg_framer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_first;
    logic       s_last;

    modport master (output s_valid, s_data, s_first, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_first, s_last, output s_ready);
endinterface

// File: rtl/hes_msg_framer.sv
// HES message framer: buffers framed plaintext bytes in a small FIFO and feeds
// the byte-stream AES cipher one byte per cycle (the cipher cannot stall us
// except through c_stall, so all elasticity lives in this FIFO).
//   clk, reset        : clock, synchronous active-high reset
//   src (slave)       : s_valid/s_ready/s_data/s_first/s_last source stream
//   key_in, key_load  : load the pending key used by the next message
//   c_stall           : suppress the pop this cycle
//   cipher_*          : registered valid_in/new_message/key/data_in to cipher
//   msg_len           : bytes emitted so far in the current message (saturating)
//   msg_done          : pulse alongside the last byte of a message
//   err_frame         : sticky framing error (cleared only by reset)
//   fifo_count        : current FIFO occupancy
module hes_msg_framer #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    hes_msg_framer_if.slave          src,
    input  logic [7:0]               key_in,
    input  logic                     key_load,
    input  logic                     c_stall,
    output logic                     cipher_valid_in,
    output logic                     cipher_new_message,
    output logic [7:0]               cipher_key,
    output logic [7:0]               cipher_data,
    output logic [LEN_W-1:0]         msg_len,
    output logic                     msg_done,
    output logic                     err_frame,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {IDLE, IN_MSG} state_t;

    state_t        state_q, state_d;
    entry_t        mem [DEPTH];
    entry_t        wr_entry, rd_entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    pending_key, active_key;
    logic          push, store, pop, frame_err;

    assign src.s_ready = (fifo_count < CW'(DEPTH));
    assign push        = src.s_valid && src.s_ready;
    assign pop         = (fifo_count != '0) && !c_stall;
    assign rd_entry    = mem[rd_ptr];
    assign cipher_key  = active_key;

    // Input FSM: decides whether a handshaked byte is stored and tracks framing.
    always_comb begin
        state_d   = state_q;
        store     = 1'b0;
        frame_err = 1'b0;
        wr_entry  = '{first: src.s_first, last: src.s_last, data: src.s_data};
        case (state_q)
            IDLE: begin
                if (push) begin
                    if (src.s_first) begin
                        store = 1'b1;
                        if (!src.s_last) state_d = IN_MSG;
                    end else begin
                        // Orphan byte outside a message: accepted but discarded.
                        frame_err = 1'b1;
                    end
                end
            end
            IN_MSG: begin
                if (push) begin
                    store = 1'b1;
                    // A fresh s_first here abandons the open message and starts a new one.
                    if (src.s_first) frame_err = 1'b1;
                    if (src.s_last)  state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Storage carries no reset; occupancy is governed by the pointers/count.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_count         <= '0;
            pending_key        <= '0;
            active_key         <= '0;
            err_frame          <= 1'b0;
            cipher_valid_in    <= 1'b0;
            cipher_new_message <= 1'b0;
            cipher_data        <= '0;
            msg_done           <= 1'b0;
            msg_len            <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);

            if (store && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!store && pop) fifo_count <= fifo_count - CW'(1);

            if (frame_err) err_frame <= 1'b1;

            // Key loaded in the same cycle as a first-byte pop only affects the
            // following message: active_key samples the old pending_key here.
            if (key_load) pending_key <= key_in;
            if (pop && rd_entry.first) active_key <= pending_key;

            cipher_valid_in    <= pop;
            cipher_new_message <= pop && rd_entry.first;
            msg_done           <= pop && rd_entry.last;
            if (pop) begin
                cipher_data <= rd_entry.data;
                if (rd_entry.first)    msg_len <= LEN_W'(1);
                else if (msg_len != '1) msg_len <= msg_len + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hes_msg_framer.sv
module tb_hes_msg_framer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_in;
    logic       key_load;
    logic       c_stall;
    logic       cipher_valid_in, cipher_new_message, msg_done, err_frame;
    logic [7:0] cipher_key, cipher_data, msg_len;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

    hes_msg_framer_if src ();

    hes_msg_framer #(.DEPTH(8), .LEN_W(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .src                (src.slave),
        .key_in             (key_in),
        .key_load           (key_load),
        .c_stall            (c_stall),
        .cipher_valid_in    (cipher_valid_in),
        .cipher_new_message (cipher_new_message),
        .cipher_key         (cipher_key),
        .cipher_data        (cipher_data),
        .msg_len            (msg_len),
        .msg_done           (msg_done),
        .err_frame          (err_frame),
        .fifo_count         (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       nm;
        logic       done;
        logic [7:0] key;
        logic [7:0] len;
    } out_t;

    out_t oq[$];

    // Record every emitted byte, sampled mid-cycle.
    always @(negedge clk)
        if (!reset && cipher_valid_in)
            oq.push_back('{cipher_data, cipher_new_message, msg_done, cipher_key, msg_len});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic nm,
                              input logic done, input logic [7:0] k, input logic [7:0] len);
        out_t o;
        out_t e;
        o = '0;
        e = '{d, nm, done, k, len};
        if (oq.size() > 0) o = oq.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    // Present one byte and hold it until it is handshaked (bounded wait).
    task automatic send(input logic [7:0] d, input logic f, input logic l);
        int budget;
        src.s_valid = 1'b1;
        src.s_data  = d;
        src.s_first = f;
        src.s_last  = l;
        budget = 0;
        while (!src.s_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!src.s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout observed s_ready=0 expected 1 for byte %h", d);
        end
        tick();
        src.s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_in = '0; key_load = 1'b0; c_stall = 1'b0;
        src.s_valid = 1'b0; src.s_data = '0; src.s_first = 1'b0; src.s_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_outs", {cipher_valid_in, cipher_new_message, msg_done, err_frame,
                           cipher_key, cipher_data, msg_len}, 32'h0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", src.s_ready, 1);

        // Basic 3-byte message, cycle-exact.
        key_in = 8'h11; key_load = 1'b1; tick(); key_load = 1'b0;
        send(8'hA0, 1, 0);
        chk("a0_latency_valid", cipher_valid_in, 0);
        chk("a0_count", fifo_count, 1);
        send(8'hA1, 0, 0);
        chk("a0_out", {cipher_valid_in, cipher_new_message, msg_done, cipher_key, cipher_data, msg_len},
            {3'b110, 8'h11, 8'hA0, 8'd1});
        send(8'hA2, 0, 1);
        chk("a1_out", {cipher_valid_in, cipher_new_message, msg_done, cipher_key, cipher_data, msg_len},
            {3'b100, 8'h11, 8'hA1, 8'd2});
        tick();
        chk("a2_out", {cipher_valid_in, cipher_new_message, msg_done, cipher_key, cipher_data, msg_len},
            {3'b101, 8'h11, 8'hA2, 8'd3});
        tick();
        chk("a_end_valid", cipher_valid_in, 0);
        oq.delete();

        // Fill under stall, then drain with the last two bytes trickling in.
        c_stall = 1'b1;
        for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i), (i == 0), 0);
        chk("full_count", fifo_count, 8);
        chk("full_ready", src.s_ready, 0);
        src.s_valid = 1'b1; src.s_data = 8'hB8; src.s_first = 1'b0; src.s_last = 1'b0;
        tick();
        chk("full_blocked_count", fifo_count, 8);
        chk("full_no_output", cipher_valid_in, 0);
        c_stall = 1'b0;
        tick();
        chk("full_pop_count", fifo_count, 7);
        send(8'hB8, 0, 0);
        chk("push_pop_count", fifo_count, 7);
        send(8'hB9, 0, 1);
        repeat (10) tick();
        for (int i = 0; i < 10; i++)
            expect_out("drain", 8'hB0 + 8'(i), (i == 0), (i == 9), 8'h11, 8'(i + 1));
        chk("drain_count", fifo_count, 0);

        // Single-byte message leaves the FSM in IDLE.
        send(8'h5A, 1, 1);
        tick(); tick();
        expect_out("single", 8'h5A, 1, 1, 8'h11, 8'd1);
        chk("clean_err", err_frame, 0);

        // Non-first byte in IDLE is accepted then dropped, and flags an error.
        send(8'h77, 0, 0);
        chk("orphan_err", err_frame, 1);
        tick(); tick();
        chk("orphan_dropped", oq.size(), 0);
        chk("orphan_count", fifo_count, 0);

        // Key changes: between messages, and coincident with a first-byte pop.
        send(8'hC0, 1, 0);
        send(8'hC1, 0, 1);
        key_in = 8'h22; key_load = 1'b1; tick(); key_load = 1'b0;
        send(8'hD0, 1, 0);
        send(8'hD1, 0, 1);
        repeat (3) tick();
        send(8'hE0, 1, 0);
        key_in = 8'h33; key_load = 1'b1;
        send(8'hE1, 0, 1);
        key_load = 1'b0;
        send(8'hF0, 1, 1);
        repeat (3) tick();
        expect_out("c0", 8'hC0, 1, 0, 8'h11, 8'd1);
        expect_out("c1", 8'hC1, 0, 1, 8'h11, 8'd2);
        expect_out("d0", 8'hD0, 1, 0, 8'h22, 8'd1);
        expect_out("d1", 8'hD1, 0, 1, 8'h22, 8'd2);
        expect_out("e0_old_key", 8'hE0, 1, 0, 8'h22, 8'd1);
        expect_out("e1_old_key", 8'hE1, 0, 1, 8'h22, 8'd2);
        expect_out("f0_new_key", 8'hF0, 1, 1, 8'h33, 8'd1);
        chk("err_sticky", err_frame, 1);

        // Reset with a partial message buffered.
        c_stall = 1'b1;
        send(8'h90, 1, 0);
        for (int i = 1; i < 5; i++) send(8'h90 + 8'(i), 0, 0);
        chk("mid_count", fifo_count, 5);
        reset = 1'b1;
        tick();
        chk("mid_reset_outs", {cipher_valid_in, cipher_new_message, msg_done, err_frame,
                               cipher_key, cipher_data, msg_len}, 32'h0);
        chk("mid_reset_count", fifo_count, 0);
        reset = 1'b0; c_stall = 1'b0;
        tick();
        chk("post_reset_idle", cipher_valid_in, 0);
        send(8'h99, 0, 0);
        chk("post_reset_from_idle_err", err_frame, 1);
        tick();
        chk("post_reset_nothing", oq.size(), 0);
        send(8'h3C, 1, 1);
        tick(); tick();
        expect_out("post_reset_msg", 8'h3C, 1, 1, 8'h00, 8'd1);
        chk("post_reset_leftover", oq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
